dense_output_serializer: RTL and testbench

- Reads the parallel result vector of a dense latency layer and streams it out one element per beat over a valid/ready interface, element 0 first.
- Sits between a dense layer's output_data and the next serial consumer (downstream stage, UART/AXI-stream bridge, or testbench scoreboard).
- Optionally applies ReLU clamping per element.
- Flags result vectors that arrive while a frame is still draining, because the dense layer cannot be back-pressured.

---
 rtl/dense_output_serializer.sv | 126 ++++++++++++
 tb/tb_dense_output_serializer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dense_output_serializer.sv
// Streams a dense layer's parallel result vector out one element per beat.
// Vectors arriving while a frame drains are counted as drops.
module dense_output_serializer #(
    parameter int WIDTH       = 5,
    parameter int OUTPUT_SIZE = 4,
    parameter int APPLY_RELU  = 1,
    parameter int CNT_WIDTH   = 8,
    localparam int IDX_W      = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] in_data [0:OUTPUT_SIZE-1],
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic signed [WIDTH-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [IDX_W-1:0]        out_index,
    output logic                    out_last,
    output logic                    overflow,
    output logic [CNT_WIDTH-1:0]    drop_count,
    input  logic                    overflow_clr
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUTPUT_SIZE - 1);

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic signed [WIDTH-1:0] buf_q [0:OUTPUT_SIZE-1];
    logic signed [WIDTH-1:0] buf_d [0:OUTPUT_SIZE-1];
    logic                    ovf_q, ovf_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;

    logic                    sending;
    logic                    at_last;
    logic                    fire;
    logic                    drop;
    logic signed [WIDTH-1:0] elem;

    always_comb begin
        sending   = (state_q == SEND);
        at_last   = sending && (idx_q == LAST_IDX);
        fire      = sending && out_ready;
        in_ready  = !sending || (fire && at_last);
        drop      = in_valid && !in_ready;

        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    buf_d   = in_data;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (fire) begin
                    if (!at_last) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else if (in_valid) begin
                        // back-to-back frame: reload without a bubble
                        buf_d = in_data;
                        idx_d = '0;
                    end else begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        ovf_d = ovf_q;
        cnt_d = cnt_q;
        if (overflow_clr) begin
            ovf_d = 1'b0;
            cnt_d = '0;
        end else if (drop) begin
            ovf_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    // Mux by comparison so a single-element vector needs no index bits.
    always_comb begin
        elem = '0;
        for (int i = 0; i < OUTPUT_SIZE; i++) begin
            if (idx_q == IDX_W'(i)) elem = buf_q[i];
        end
    end

    always_comb begin
        out_valid = sending;
        out_last  = at_last;
        out_index = idx_q;
        out_data  = '0;
        if (sending) begin
            if ((APPLY_RELU != 0) && elem[WIDTH-1]) out_data = '0;
            else out_data = elem;
        end
        overflow   = ovf_q;
        drop_count = cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            for (int i = 0; i < OUTPUT_SIZE; i++) buf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < OUTPUT_SIZE; i++) buf_q[i] <= buf_d[i];
        end
    end

endmodule

// File: tb/tb_dense_output_serializer.sv
// Directed checks of dense_output_serializer: ReLU, stalls, back-to-back,
// drops, mid-frame reset and single-element vectors.
module tb_dense_output_serializer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // instance A: 4 elements, ReLU on
    logic signed [4:0] a_in [0:3];
    logic a_iv = 0, a_ir, a_ov, a_or = 0, a_last, a_ovf, a_clr = 0;
    logic signed [4:0] a_od;
    logic [1:0] a_idx;
    logic [7:0] a_cnt;

    // instance B: 4 elements, ReLU off
    logic signed [4:0] b_in [0:3];
    logic b_iv = 0, b_ir, b_ov, b_or = 0, b_last, b_ovf, b_clr = 0;
    logic signed [4:0] b_od;
    logic [1:0] b_idx;
    logic [7:0] b_cnt;

    // instance C: 1 element, ReLU on
    logic signed [4:0] c_in [0:0];
    logic c_iv = 0, c_ir, c_ov, c_or = 0, c_last, c_ovf, c_clr = 0;
    logic signed [4:0] c_od;
    logic [0:0] c_idx;
    logic [7:0] c_cnt;

    dense_output_serializer #(.WIDTH(5), .OUTPUT_SIZE(4), .APPLY_RELU(1), .CNT_WIDTH(8)) dut_a (
        .clk(clk), .reset(reset), .in_data(a_in), .in_valid(a_iv), .in_ready(a_ir),
        .out_data(a_od), .out_valid(a_ov), .out_ready(a_or), .out_index(a_idx),
        .out_last(a_last), .overflow(a_ovf), .drop_count(a_cnt), .overflow_clr(a_clr)
    );

    dense_output_serializer #(.WIDTH(5), .OUTPUT_SIZE(4), .APPLY_RELU(0), .CNT_WIDTH(8)) dut_b (
        .clk(clk), .reset(reset), .in_data(b_in), .in_valid(b_iv), .in_ready(b_ir),
        .out_data(b_od), .out_valid(b_ov), .out_ready(b_or), .out_index(b_idx),
        .out_last(b_last), .overflow(b_ovf), .drop_count(b_cnt), .overflow_clr(b_clr)
    );

    dense_output_serializer #(.WIDTH(5), .OUTPUT_SIZE(1), .APPLY_RELU(1), .CNT_WIDTH(8)) dut_c (
        .clk(clk), .reset(reset), .in_data(c_in), .in_valid(c_iv), .in_ready(c_ir),
        .out_data(c_od), .out_valid(c_ov), .out_ready(c_or), .out_index(c_idx),
        .out_last(c_last), .overflow(c_ovf), .drop_count(c_cnt), .overflow_clr(c_clr)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_a(input int e0, input int e1, input int e2, input int e3);
        a_in[0] = 5'(e0);
        a_in[1] = 5'(e1);
        a_in[2] = 5'(e2);
        a_in[3] = 5'(e3);
    endtask

    task automatic a_beat(input string t, input int d, input int i, input int l);
        chk({t, ".valid"}, int'(a_ov), 1);
        chk({t, ".data"}, int'(a_od), d);
        chk({t, ".index"}, int'(a_idx), i);
        chk({t, ".last"}, int'(a_last), l);
    endtask

    int r1[4] = '{3, 0, 7, 0};
    int v1[4] = '{3, -2, 7, -16};
    int v5[4] = '{5, 4, 3, 2};
    int rp[7] = '{1, 0, 0, 1, 1, 0, 1};

    initial begin
        int e;
        set_a(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) b_in[i] = '0;
        c_in[0] = '0;

        // reset state
        #1;
        chk("rst.valid", int'(a_ov), 0);
        chk("rst.ready", int'(a_ir), 1);
        chk("rst.data", int'(a_od), 0);
        chk("rst.index", int'(a_idx), 0);
        chk("rst.last", int'(a_last), 0);
        chk("rst.ovf", int'(a_ovf), 0);
        chk("rst.cnt", int'(a_cnt), 0);
        tick();
        reset = 1'b0;

        // ReLU stream, out_ready held high
        tick();
        set_a(3, -2, 7, -16);
        a_iv = 1; a_or = 1;
        #1 chk("t1.capready", int'(a_ir), 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            a_iv = 0;
            #1 a_beat($sformatf("t1.b%0d", k), r1[k], k, int'(k == 3));
        end
        tick();
        #1;
        chk("t1.idle.valid", int'(a_ov), 0);
        chk("t1.idle.ready", int'(a_ir), 1);

        // no ReLU, out_ready toggling
        tick();
        for (int i = 0; i < 4; i++) b_in[i] = 5'(v1[i]);
        b_iv = 1; b_or = 0;
        e = 0;
        for (int c = 0; c < 7; c++) begin
            tick();
            b_iv = 0;
            b_or = rp[c][0];
            #1;
            chk($sformatf("t2.c%0d.valid", c), int'(b_ov), 1);
            chk($sformatf("t2.c%0d.data", c), int'(b_od), v1[e]);
            chk($sformatf("t2.c%0d.index", c), int'(b_idx), e);
            chk($sformatf("t2.c%0d.last", c), int'(b_last), int'(e == 3));
            if (rp[c] != 0) e++;
        end
        tick();
        #1 chk("t2.idle.valid", int'(b_ov), 0);

        // back-to-back frames
        tick();
        set_a(3, -2, 7, -16);
        a_iv = 1; a_or = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 3) begin
                set_a(1, 1, 1, 1);
                a_iv = 1;
            end else begin
                a_iv = 0;
            end
            #1 a_beat($sformatf("t3.f1b%0d", k), r1[k], k, int'(k == 3));
            if (k == 3) chk("t3.b2bready", int'(a_ir), 1);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            a_iv = 0;
            #1 a_beat($sformatf("t3.f2b%0d", k), 1, k, int'(k == 3));
        end
        tick();
        #1 chk("t3.idle.valid", int'(a_ov), 0);

        // drops while stalled at index 1
        tick();
        set_a(3, -2, 7, -16);
        a_iv = 1; a_or = 1;
        tick();
        a_iv = 0;
        #1 a_beat("t4.b0", 3, 0, 0);
        for (int c = 0; c < 6; c++) begin
            tick();
            a_or = 0;
            a_iv = (c % 2 == 0);
            #1;
            a_beat($sformatf("t4.hold%0d", c), 0, 1, 0);
            chk($sformatf("t4.hold%0d.ready", c), int'(a_ir), 0);
        end
        tick();
        a_iv = 0;
        #1;
        chk("t4.ovf", int'(a_ovf), 1);
        chk("t4.cnt", int'(a_cnt), 3);
        tick();
        a_iv = 1; a_clr = 1;
        tick();
        a_iv = 0; a_clr = 0; a_or = 1;
        #1;
        chk("t4.clr.ovf", int'(a_ovf), 0);
        chk("t4.clr.cnt", int'(a_cnt), 0);
        a_beat("t4.b1", 0, 1, 0);
        for (int k = 2; k < 4; k++) begin
            tick();
            #1 a_beat($sformatf("t4.b%0d", k), r1[k], k, int'(k == 3));
        end
        tick();
        #1 chk("t4.idle.valid", int'(a_ov), 0);

        // reset mid-frame at index 2
        tick();
        set_a(3, -2, 7, -16);
        a_iv = 1; a_or = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            a_iv = 0;
            #1 a_beat($sformatf("t5.b%0d", k), r1[k], k, 0);
        end
        reset = 1'b1;
        #1;
        chk("t5.rst.valid", int'(a_ov), 0);
        chk("t5.rst.index", int'(a_idx), 0);
        tick();
        reset = 1'b0;
        #1;
        chk("t5.rel.ready", int'(a_ir), 1);
        chk("t5.rel.valid", int'(a_ov), 0);
        tick();
        set_a(5, 4, 3, 2);
        a_iv = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            a_iv = 0;
            #1 a_beat($sformatf("t5.n%0d", k), v5[k], k, int'(k == 3));
        end

        // single-element vectors every cycle
        tick();
        c_in[0] = -5'sd1;
        c_iv = 1; c_or = 1;
        #1 chk("t6.capready", int'(c_ir), 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            #1;
            chk($sformatf("t6.b%0d.valid", k), int'(c_ov), 1);
            chk($sformatf("t6.b%0d.data", k), int'(c_od), 0);
            chk($sformatf("t6.b%0d.last", k), int'(c_last), 1);
            chk($sformatf("t6.b%0d.index", k), int'(c_idx), 0);
            chk($sformatf("t6.b%0d.ready", k), int'(c_ir), 1);
            chk($sformatf("t6.b%0d.ovf", k), int'(c_ovf), 0);
        end
        tick();
        c_iv = 0;
        #1 chk("t6.tail.valid", int'(c_ov), 1);
        tick();
        #1 chk("t6.idle.valid", int'(c_ov), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
